// File: rtl/ram_req_initiator.sv
// ram_req_initiator: load/store command FIFO feeding a single-outstanding
// req/resp memory master, with a timeout fallback and an in-order completion port.
module ram_req_initiator #(
  parameter int WORD_W     = 32,
  parameter int CMDQ_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [WORD_W-1:0] cmd_addr,
  input  logic [WORD_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              w_req,
  output logic [WORD_W-1:0] w_addr,
  output logic [WORD_W-1:0] w_data,
  input  logic              w_resp,
  output logic              r_req,
  output logic [WORD_W-1:0] r_addr,
  input  logic [WORD_W-1:0] r_data,
  input  logic              r_resp,
  output logic              busy
);

  localparam int AW   = $clog2(CMDQ_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(TIMEOUT);

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  cmd_t [CMDQ_DEPTH-1:0] mem_q;
  logic [AW-1:0]         wr_q, rd_q;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  push, pop;
  cmd_t                  cmd_in, head;

  state_t                state_q;
  logic                  we_q;
  logic [WORD_W-1:0]     addr_q, wdata_q;
  logic [CW-1:0]         tmo_q;
  logic                  w_req_q, r_req_q;
  logic                  rsp_valid_q, rsp_we_q, rsp_err_q;
  logic [WORD_W-1:0]     rsp_rdata_q;
  logic                  got_resp;

  assign cmd_in   = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
  assign head     = mem_q[rd_q];
  assign push     = cmd_valid & cmd_ready;
  assign pop      = (state_q == IDLE) & ~empty_q;
  // Only the ack matching the request kind counts, and only while issuing.
  assign got_resp = we_q ? w_resp : r_resp;

  // Next occupancy drives the registered full/empty flags.
  always_comb begin
    cnt_d   = cnt_q + CNTW'(push) - CNTW'(pop);
    full_d  = (cnt_d == CNTW'(CMDQ_DEPTH));
    empty_d = (cnt_d == '0);
  end

  // Command storage; contents need no reset since empty guards every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= cmd_in;
  end

  // FIFO pointers and occupancy flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Request FSM: pop one command, hold its request until ack or timeout,
  // then present the completion until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tmo_q       <= '0;
      w_req_q     <= 1'b0;
      r_req_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty_q) begin
            we_q    <= head.we;
            addr_q  <= head.addr;
            wdata_q <= head.wdata;
            w_req_q <= head.we;
            r_req_q <= ~head.we;
            tmo_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_q <= tmo_q + CW'(1);
          if (got_resp) begin
            w_req_q     <= 1'b0;
            r_req_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= we_q;
            rsp_rdata_q <= we_q ? '0 : r_data;
            rsp_err_q   <= 1'b0;
            state_q     <= RESP;
          end else if (tmo_q == CW'(TIMEOUT - 1)) begin
            w_req_q     <= 1'b0;
            r_req_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= we_q;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = ~full_q & ~reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign w_req     = w_req_q;
  assign r_req     = r_req_q;
  assign w_addr    = addr_q;
  assign r_addr    = addr_q;
  assign w_data    = wdata_q;
  assign busy      = ~empty_q | (state_q != IDLE);

endmodule

// File: tb/tb_ram_req_initiator.sv
// Bench for ram_req_initiator: a behavioural RAM (addresses >= 16 never answer),
// an in-order expected-completion queue built from command semantics, and a
// cycle monitor for handshake stability, request exclusivity and timeout length.
module tb_ram_req_initiator;
  localparam int W   = 32;
  localparam int D   = 4;
  localparam int TMO = 16;

  logic         clk = 1'b0, reset = 1'b1;
  logic         cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [W-1:0] cmd_addr = '0, cmd_wdata = '0;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_we, rsp_err;
  logic [W-1:0] rsp_rdata;
  logic         w_req, w_resp = 1'b0, r_req, r_resp = 1'b0;
  logic [W-1:0] w_addr, w_data, r_addr, r_data = '0;
  logic         busy;

  always #5 clk = ~clk;

  ram_req_initiator #(.WORD_W(W), .CMDQ_DEPTH(D), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_resp(w_resp),
    .r_req(r_req), .r_addr(r_addr), .r_data(r_data), .r_resp(r_resp),
    .busy(busy)
  );

  typedef struct { logic we; logic [W-1:0] rdata; logic err; } exp_t;
  exp_t         expq[$];
  exp_t         mon_e;
  logic [W-1:0] ref_mem[16];
  logic [W-1:0] ram_mem[16];
  int           n_chk = 0, n_pass = 0, n_rsp = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural RAM: answers after a per-request latency, pulses its ack one
  // extra cycle (like a registered ack), and never answers unmapped addresses.
  int   age = 0, lat = 0, wlat_fix = -1, rlat_fix = -1;
  logic extra_w = 1'b0, extra_r = 1'b0;
  always @(negedge clk) begin
    w_resp = 1'b0;
    r_resp = 1'b0;
    if (reset) begin
      age = 0; extra_w = 1'b0; extra_r = 1'b0;
    end else begin
      if (extra_w) w_resp = 1'b1;
      if (extra_r) begin r_resp = 1'b1; r_data = $urandom; end
      extra_w = 1'b0;
      extra_r = 1'b0;
      if (w_req || r_req) begin
        age++;
        if (age == 1)
          lat = w_req ? ((wlat_fix >= 0) ? wlat_fix : $urandom_range(0, 3))
                      : ((rlat_fix >= 0) ? rlat_fix : $urandom_range(0, 3));
        if (age == lat + 1) begin
          if (w_req && w_addr < 16) begin
            ram_mem[w_addr[3:0]] = w_data; w_resp = 1'b1; extra_w = 1'b1; age = 0;
          end else if (r_req && r_addr < 16) begin
            r_data = ram_mem[r_addr[3:0]]; r_resp = 1'b1; extra_r = 1'b1; age = 0;
          end
        end
      end else age = 0;
    end
  end

  // Consumer readiness: fixed or random.
  logic rnd_rdy = 1'b0, rdy_fix = 1'b1;
  always @(negedge clk) rsp_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_fix;

  // Monitor, sampled just after the falling edge.
  logic         hold_v = 1'b0, hold_we, hold_err;
  logic [W-1:0] hold_rdata, rrun_addr;
  int           rrun = 0;
  always @(negedge clk) begin
    #1;
    if (reset) begin
      hold_v = 1'b0; rrun = 0;
    end else begin
      chk("req_excl", w_req & r_req, 0);
      if (rsp_valid) chk("req_during_rsp", w_req | r_req, 0);
      if (hold_v) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_rdata", rsp_rdata, hold_rdata);
        chk("hold_we", rsp_we, hold_we);
        chk("hold_err", rsp_err, hold_err);
      end
      hold_v = rsp_valid && !rsp_ready;
      hold_rdata = rsp_rdata; hold_we = rsp_we; hold_err = rsp_err;
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (expq.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          mon_e = expq.pop_front();
          chk("rsp_we", rsp_we, mon_e.we);
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_err", rsp_err, mon_e.err);
        end
      end
      if (r_req) begin
        rrun++; rrun_addr = r_addr;
      end else if (rrun > 0) begin
        if (rrun_addr >= 16) chk("timeout_len", rrun, TMO);
        else chk("read_len_bounded", rrun <= 4, 1);
        rrun = 0;
      end
    end
  end

  // Offer one command; returns in the cycle it is accepted (valid still high).
  task automatic send(input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    int   w = 0;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    #1;
    while (!cmd_ready && w < 300) begin w++; @(negedge clk); #1; end
    if (!cmd_ready) begin chk("cmd_accept_timeout", 0, 1); cmd_valid = 1'b0; return; end
    e.we = we; e.err = (a >= 16); e.rdata = '0;
    if (!e.err) begin
      if (we) ref_mem[a[3:0]] = d;
      else    e.rdata = ref_mem[a[3:0]];
    end
    expq.push_back(e);
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while ((expq.size() != 0 || busy || rsp_valid) && w < 2000) begin @(negedge clk); w++; end
    #1;
    chk("drained", (expq.size() == 0) && !busy, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int base, w;
  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h0101_0101 * i;
      ram_mem[i] = 32'h0101_0101 * i;
    end
    // Reset held, then released.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_reqs", {w_req, r_req}, 0);
    chk("rst_rsp_fields", {rsp_we, rsp_err, rsp_rdata}, 0);
    @(negedge clk); reset = 1'b0; #1;
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_busy", busy, 0);

    // Write then read at address 5 with fixed RAM latencies.
    wlat_fix = 1; rlat_fix = 0; base = n_rsp;
    send(1'b1, 5, 32'hDEAD_BEEF);
    @(negedge clk); cmd_valid = 1'b0; #1;
    chk("wr_req_n1", w_req, 0);
    @(negedge clk); #1;
    chk("wr_req_n2", w_req, 1);
    chk("wr_addr", w_addr, 5);
    chk("wr_data", w_data, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    chk("wr_rsp_n3", rsp_valid, 0);
    @(negedge clk); #1;
    chk("wr_rsp_n4", rsp_valid, 1);
    wait_idle();
    send(1'b0, 5, 0);
    @(negedge clk); cmd_valid = 1'b0; #1;
    chk("rd_req_n1", r_req, 0);
    @(negedge clk); #1;
    chk("rd_req_n2", r_req, 1);
    chk("rd_addr", r_addr, 5);
    @(negedge clk); #1;
    chk("rd_rsp_n3", rsp_valid, 1);
    chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    wait_idle();
    chk("wr_rd_count", n_rsp - base, 2);

    // Burst with stalled consumer: one in flight plus a full FIFO.
    rdy_fix = 1'b0; base = n_rsp;
    for (int i = 0; i < 5; i++) send(i[0], 32'(i + 8), 32'hA000_0000 + 32'(i));
    @(negedge clk); cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("burst_full_ready", cmd_ready, 0);
    chk("burst_busy", busy, 1);
    rdy_fix = 1'b1;
    send(1'b0, 9, 0);
    wait_idle();
    chk("burst_count", n_rsp - base, 6);

    // Backpressure: completion must hold, nothing further issued.
    rdy_fix = 1'b0;
    send(1'b0, 7, 0);
    send(1'b1, 8, 32'h1234_5678);
    @(negedge clk); cmd_valid = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("bp_valid", rsp_valid, 1);
    chk("bp_no_req", w_req | r_req, 0);
    rdy_fix = 1'b1;
    wait_idle();

    // Timeout on an unmapped read, then normal traffic behind it.
    base = n_rsp;
    send(1'b0, 17, 0);
    send(1'b1, 2, 32'h0BAD_F00D);
    send(1'b0, 2, 0);
    wait_idle();
    chk("tmo_count", n_rsp - base, 3);

    // Random traffic with random latencies and consumer stalls.
    wlat_fix = -1; rlat_fix = -1; rnd_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(negedge clk); cmd_valid = 1'b0; end
      send(1'($urandom_range(0, 1)), 32'($urandom_range(0, 19)), $urandom);
    end
    wait_idle();
    rnd_rdy = 1'b0; rdy_fix = 1'b1;

    // Reset while a write is outstanding with three more queued.
    for (int i = 0; i < 4; i++) send(1'b1, 32'(20 + i), 32'(i));
    @(negedge clk); cmd_valid = 1'b0; #1;
    w = 0;
    while (!w_req && w < 20) begin @(negedge clk); #1; w++; end
    chk("mid_wreq_up", w_req, 1);
    @(posedge clk); #3;
    reset = 1'b1; #1;
    chk("mid_rst_wreq", w_req, 0);
    chk("mid_rst_rreq", r_req, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    expq.delete();
    base = n_rsp;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("post_rst_no_rsp", n_rsp - base, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_wreq", w_req, 0);
    chk("post_rst_ready", cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
